vga_rect_fill: RTL and testbench
================================

VGA_RECT_FILL -- requirements
Module: vga_rect_fill

Interface
REQ-001 SHALL have parameter RESOLUTION, default "320x240", screen size in dots ("320x240" or "160x120").
REQ-002 SHALL have parameter BITS_PER_COLOUR_CHANNEL, default 1, bits per R/G/B channel.
REQ-003 SHALL have parameter MONOCHROME, default "FALSE"; "TRUE" makes the colour width 1.
REQ-004 Width terms: XW = 9 for 320x240 or 8 for 160x120; YW = 8 or 7; CW = 1 if MONOCHROME, else 3*BITS_PER_COLOUR_CHANNEL.
REQ-005 SHALL have port vga_clock, input, 1 bit, clock; all logic on its rising edge.
REQ-006 SHALL have port resetn, input, 1 bit, reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit, request a fill.
REQ-008 SHALL have port abort, input, 1 bit, cancel the current fill.
REQ-009 SHALL have port x0, input, XW bits, left column.
REQ-010 SHALL have port y0, input, YW bits, top row.
REQ-011 SHALL have port width, input, XW+1 bits, column count.
REQ-012 SHALL have port height, input, YW+1 bits, row count.
REQ-013 SHALL have port colour, input, CW bits, fill colour.
REQ-014 SHALL have port x, output, XW bits, plot column for the video-memory write port.
REQ-015 SHALL have port y, output, YW bits, plot row.
REQ-016 SHALL have port colour_out, output, CW bits, plot colour.
REQ-017 SHALL have port plot, output, 1 bit, write enable, one dot per asserted cycle.
REQ-018 SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-019 SHALL have port done, output, 1 bit, one-cycle completion pulse.

Function
REQ-020 States SHALL be IDLE, LOAD, DRAW and FINISH; all outputs SHALL be registered.
REQ-021 In IDLE with start=1, SHALL capture x0, y0, width, height and colour, then go to LOAD; inputs are ignored after capture.
REQ-022 start SHALL be ignored whenever the state is not IDLE.
REQ-023 In LOAD, SHALL compute the clipped ends, using XW+2-bit and YW+2-bit arithmetic so they cannot overflow:
- x_end = min(x0+width, HMAX) - 1
- y_end = min(y0+height, VMAX) - 1
- HMAX/VMAX = 320/240 or 160/120.
REQ-024 LOAD SHALL go to FINISH with no plot if width=0, height=0, x0>=HMAX or y0>=VMAX; otherwise it SHALL go to DRAW.
REQ-025 DRAW SHALL emit one dot per cycle in raster order, x then y, starting at (x0,y0), with plot=1 and colour_out equal to the captured colour.
REQ-026 At x=x_end, the next dot SHALL be x=x0, y=y+1.
REQ-027 At (x_end,y_end), the next state SHALL be FINISH.
REQ-028 The first plot=1 SHALL appear on the 2nd rising edge after the edge that samples start.
REQ-029 A fill SHALL emit exactly (x_end-x0+1)*(y_end-y0+1) consecutive plot cycles.
REQ-030 FINISH SHALL assert done=1 and plot=0 for one cycle, then return to IDLE with busy=0.
REQ-031 abort=1, sampled in LOAD, DRAW or FINISH, SHALL return to IDLE on that edge: plot=0, busy=0, no done pulse; abort takes priority over every other transition.
REQ-032 abort=1 in IDLE SHALL have no effect, and start is not accepted on that cycle.
REQ-033 plot SHALL never be 1 with x>=HMAX or y>=VMAX.
REQ-034 x, y and colour_out SHALL hold their last values while plot=0.

Reset
REQ-035 resetn=0 SHALL immediately force state=IDLE and x=0, y=0, colour_out=0, plot=0, busy=0, done=0.
REQ-036 Reset SHALL discard any fill in progress, including one in DRAW; after release, no plot occurs until a new start.

Verification
REQ-037 320x240, start with x0=10, y0=20, width=3, height=2, colour=3'b101 -> plot for 6 cycles at (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), then done for 1 cycle; first plot 2 edges after start.
REQ-038 Clipping: x0=318, y0=238, width=5, height=5 -> 4 dots (318,238),(319,238),(318,239),(319,239), then done.
REQ-039 Empty fills: width=0, then separately x0=320 -> no plot, done on the 2nd edge after start, busy high for 2 cycles.
REQ-040 Abort: full-screen fill, abort asserted on the 100th plot cycle -> plot=0 and busy=0 on the next cycle, no done; a following start with width=1, height=1 fills a single dot.
REQ-041 start held high during a fill -> ignored while busy, a single done; start still high in IDLE starts a new fill.
REQ-042 resetn pulsed low mid-DRAW, asynchronously between edges -> all outputs 0 immediately; with 160x120, a full-screen fill yields 19200 plots and a maximum x of 159.

Source files
------------

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine for a VGA video-memory write port.
// A start request captures a rectangle, and the ends are clipped to the screen.
// The engine then plots one dot per clock in raster order and signals completion.
module vga_rect_fill #(
    parameter string RESOLUTION              = "320x240",
    parameter int    BITS_PER_COLOUR_CHANNEL = 1,
    parameter string MONOCHROME              = "FALSE",
    localparam int   XW = (RESOLUTION == "160x120") ? 8 : 9,
    localparam int   YW = (RESOLUTION == "160x120") ? 7 : 8,
    localparam int   CW = (MONOCHROME == "TRUE") ? 1 : 3 * BITS_PER_COLOUR_CHANNEL
) (
    input  logic          vga_clock,
    input  logic          resetn,
    input  logic          start,
    input  logic          abort,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW:0]   width,
    input  logic [YW:0]   height,
    input  logic [CW-1:0] colour,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour_out,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    localparam int HMAX = (XW == 8) ? 160 : 320;
    localparam int VMAX = (YW == 7) ? 120 : 240;
    localparam logic [XW+1:0] HMAX_L = (XW+2)'(HMAX);
    localparam logic [YW+1:0] VMAX_L = (YW+2)'(VMAX);
    localparam logic [XW+1:0] XL_ONE = (XW+2)'(1);
    localparam logic [YW+1:0] YL_ONE = (YW+2)'(1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, FINISH} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x0_q, x0_d, cx_q, cx_d, x_q, x_d;
    logic [YW-1:0] y0_q, y0_d, cy_q, cy_d, y_q, y_d;
    logic [XW:0]   w_q, w_d;
    logic [YW:0]   h_q, h_d;
    logic [CW-1:0] col_q, col_d, colour_out_q, colour_out_d;
    // Clipped ends kept at full arithmetic width so the top bits never dangle
    logic [XW+1:0] xend_q, xend_d;
    logic [YW+1:0] yend_q, yend_d;
    logic          plot_q, plot_d, busy_q, busy_d, done_q, done_d;

    logic [XW+1:0] x_sum, x_clip, x_last;
    logic [YW+1:0] y_sum, y_clip, y_last;
    logic          empty;

    // Next-state and registered-output logic; abort overrides every transition
    always_comb begin
        state_d      = state_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        w_d          = w_q;
        h_d          = h_q;
        col_d        = col_q;
        xend_d       = xend_q;
        yend_d       = yend_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_out_d = colour_out_q;
        plot_d       = 1'b0;
        done_d       = 1'b0;

        // Two extra bits of headroom so x0+width cannot wrap before clipping
        x_sum  = {2'b00, x0_q} + {1'b0, w_q};
        y_sum  = {2'b00, y0_q} + {1'b0, h_q};
        x_clip = (x_sum > HMAX_L) ? HMAX_L : x_sum;
        y_clip = (y_sum > VMAX_L) ? VMAX_L : y_sum;
        x_last = x_clip - XL_ONE;
        y_last = y_clip - YL_ONE;
        empty  = (w_q == '0) || (h_q == '0) ||
                 ({2'b00, x0_q} >= HMAX_L) || ({2'b00, y0_q} >= VMAX_L);

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    w_d     = width;
                    h_d     = height;
                    col_d   = colour;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                xend_d  = x_last;
                yend_d  = y_last;
                cx_d    = x0_q;
                cy_d    = y0_q;
                state_d = empty ? FINISH : DRAW;
            end
            DRAW: begin
                plot_d       = 1'b1;
                x_d          = cx_q;
                y_d          = cy_q;
                colour_out_d = col_q;
                if ({2'b00, cx_q} == xend_q) begin
                    cx_d = x0_q;
                    if ({2'b00, cy_q} == yend_q) state_d = FINISH;
                    else                         cy_d    = cy_q + Y_ONE;
                end else begin
                    cx_d = cx_q + X_ONE;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) begin
            state_d      = IDLE;
            plot_d       = 1'b0;
            done_d       = 1'b0;
            x_d          = x_q;
            y_d          = y_q;
            colour_out_d = colour_out_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously by resetn
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            x0_q         <= '0;
            y0_q         <= '0;
            w_q          <= '0;
            h_q          <= '0;
            col_q        <= '0;
            xend_q       <= '0;
            yend_q       <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            colour_out_q <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            w_q          <= w_d;
            h_q          <= h_d;
            col_q        <= col_d;
            xend_q       <= xend_d;
            yend_q       <= yend_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_out_q <= colour_out_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour_out = colour_out_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Bench for vga_rect_fill: expected per-cycle output trace built from rectangle geometry.
module tb_vga_rect_fill;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0, abort = 1'b0;
    logic [8:0] x0 = '0;
    logic [7:0] y0 = '0;
    logic [9:0] width = '0;
    logic [8:0] height = '0;
    logic [2:0] colour = '0;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] colour_out;
    logic       plot, busy, done;

    logic       start2 = 1'b0, abort2 = 1'b0;
    logic [7:0] x0b = '0;
    logic [6:0] y0b = '0;
    logic [8:0] wb = 9'd160;
    logic [7:0] hb = 8'd120;
    logic [2:0] colb = 3'd7;
    logic [7:0] x2;
    logic [6:0] y2;
    logic [2:0] c2;
    logic       plot2, busy2, done2;

    always #5 clk = ~clk;

    vga_rect_fill dut (
        .vga_clock(clk), .resetn(resetn), .start(start), .abort(abort),
        .x0(x0), .y0(y0), .width(width), .height(height), .colour(colour),
        .x(x), .y(y), .colour_out(colour_out), .plot(plot), .busy(busy), .done(done)
    );

    vga_rect_fill #(.RESOLUTION("160x120")) dut2 (
        .vga_clock(clk), .resetn(resetn), .start(start2), .abort(abort2),
        .x0(x0b), .y0(y0b), .width(wb), .height(hb), .colour(colb),
        .x(x2), .y(y2), .colour_out(c2), .plot(plot2), .busy(busy2), .done(done2)
    );

    typedef struct {
        logic plot, busy, done;
        int   x, y, c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, failures = 0;
    int   mx = 0, my = 0, mc = 0;
    int   plot_cnt = 0, done_cnt = 0, cyc = 0;
    bit   trunc_req = 0;
    int   p2cnt = 0, maxx2 = 0, oob2 = 0, d2cnt = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, expv);
        end
    endtask

    // Expected trace of one fill, one entry per cycle after the start-sampling edge
    task automatic push_fill(input int ax, input int ay, input int aw, input int ah, input int ac);
        exp_t e;
        e = '{plot: 1'b0, busy: 1'b1, done: 1'b0, x: 0, y: 0, c: 0};
        exp_q.push_back(e);
        exp_q.push_back(e);
        for (int yy = ay; yy < ay + ah && yy < 240; yy++)
            for (int xx = ax; xx < ax + aw && xx < 320; xx++) begin
                e = '{plot: 1'b1, busy: 1'b1, done: 1'b0, x: xx, y: yy, c: ac};
                exp_q.push_back(e);
            end
        e = '{plot: 1'b0, busy: 1'b0, done: 1'b1, x: 0, y: 0, c: 0};
        exp_q.push_back(e);
    endtask

    task automatic set_in(input int ax, input int ay, input int aw, input int ah, input int ac);
        x0 = ax[8:0]; y0 = ay[7:0]; width = aw[9:0]; height = ah[8:0]; colour = ac[2:0];
    endtask

    task automatic launch(input int ax, input int ay, input int aw, input int ah, input int ac);
        set_in(ax, ay, aw, ah, ac);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_fill(ax, ay, aw, ah, ac);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d_left expected=0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Single compare process: every cycle the DUT outputs must match the model trace
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!resetn) begin
            exp_q.delete();
            trunc_req = 0;
            mx = 0; my = 0; mc = 0;
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{plot: 1'b0, busy: 1'b0, done: 1'b0, x: 0, y: 0, c: 0};
        if (!e.plot) begin
            e.x = mx; e.y = my; e.c = mc;
        end
        checks++;
        if (plot !== e.plot || busy !== e.busy || done !== e.done ||
            int'(x) != e.x || int'(y) != e.y || int'(colour_out) != e.c) begin
            failures++;
            $display("FAIL cycle_%0d got plot=%0b busy=%0b done=%0b x=%0d y=%0d c=%0d expected plot=%0b busy=%0b done=%0b x=%0d y=%0d c=%0d",
                     cyc, plot, busy, done, x, y, colour_out, e.plot, e.busy, e.done, e.x, e.y, e.c);
        end
        if (e.plot) begin
            mx = e.x; my = e.y; mc = e.c;
        end
        if (plot === 1'b1) plot_cnt++;
        if (done === 1'b1) done_cnt++;
        if (trunc_req) begin
            exp_q.delete();
            trunc_req = 0;
        end
    end

    // Statistics for the 160x120 instance
    always @(negedge clk) begin
        if (plot2 === 1'b1) begin
            p2cnt++;
            if (int'(x2) > maxx2) maxx2 = int'(x2);
            if (int'(x2) >= 160 || int'(y2) >= 120) oob2++;
        end
        if (done2 === 1'b1) d2cnt++;
    end

    initial begin
        int p0, d0;
        #3;
        chk("reset_x", int'(x), 0);
        chk("reset_plot_busy_done", int'({plot, busy, done}), 0);
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        @(posedge clk); #1;

        // Basic 3x2 fill
        p0 = plot_cnt; d0 = done_cnt;
        launch(10, 20, 3, 2, 5);
        wait_drain(50);
        chk("basic_plots", plot_cnt - p0, 6);
        chk("basic_dones", done_cnt - d0, 1);
        chk("basic_hold_x", int'(x), 12);
        chk("basic_hold_y", int'(y), 21);
        chk("basic_hold_c", int'(colour_out), 5);

        // Clipped at bottom-right corner
        p0 = plot_cnt;
        launch(318, 238, 5, 5, 2);
        wait_drain(50);
        chk("clip_plots", plot_cnt - p0, 4);
        chk("clip_last_xy", int'(x) * 1000 + int'(y), 319239);

        // Empty fills: zero width, then off-screen x0
        p0 = plot_cnt; d0 = done_cnt;
        launch(10, 20, 0, 2, 1);
        wait_drain(20);
        launch(320, 20, 3, 2, 1);
        wait_drain(20);
        chk("empty_plots", plot_cnt - p0, 0);
        chk("empty_dones", done_cnt - d0, 2);

        // Full-screen fill aborted on the 100th plot cycle
        p0 = plot_cnt; d0 = done_cnt;
        launch(0, 0, 320, 240, 6);
        repeat (101) @(posedge clk);
        #1;
        abort = 1'b1;
        trunc_req = 1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_drain(20);
        chk("abort_plots", plot_cnt - p0, 100);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_hold_x", int'(x), 99);
        p0 = plot_cnt;
        launch(5, 7, 1, 1, 2);
        wait_drain(20);
        chk("single_dot_plots", plot_cnt - p0, 1);
        chk("single_dot_xy", int'(x) * 1000 + int'(y), 5007);

        // start and abort together in IDLE: nothing happens
        set_in(1, 1, 4, 4, 3);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_abort_busy", int'(busy), 0);

        // start held high: one fill, one done, then a second fill from IDLE
        p0 = plot_cnt; d0 = done_cnt;
        set_in(1, 1, 2, 1, 3);
        start = 1'b1;
        @(posedge clk); #1;
        push_fill(1, 1, 2, 1, 3);
        push_fill(1, 1, 2, 1, 3);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain(30);
        chk("held_start_plots", plot_cnt - p0, 4);
        chk("held_start_dones", done_cnt - d0, 2);

        // Reset pulsed between edges in the middle of DRAW
        launch(0, 0, 50, 50, 4);
        repeat (20) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("rst_mid_xy", int'(x) + int'(y), 0);
        chk("rst_mid_c", int'(colour_out), 0);
        chk("rst_mid_flags", int'({plot, busy, done}), 0);
        @(posedge clk); #2;
        resetn = 1'b1;
        p0 = plot_cnt;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_plot_after", plot_cnt - p0, 0);

        // 160x120 full-screen fill on the second instance
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int i = 0; i < 19500 && d2cnt == 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("small_done", d2cnt, 1);
        chk("small_plots", p2cnt, 19200);
        chk("small_max_x", maxx2, 159);
        chk("small_oob", oob2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
